operand_sel_stage: RTL and testbench

Parametrised N-way operand select stage with a registered, elastic output for the pipelined datapath. It generalises the 3-input forwarding mux to any width and input count. The selected word is registered behind a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops or duplicates an operand. The stage sits between the hazard/forwarding unit and the EX-stage ALU operand inputs, and adds flush support and a saturating illegal-select counter.

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/sel_mux_comb.sv | 27 ++
 rtl/operand_sel_stage.sv | 100 ++++++++++
 tb/tb_operand_sel_stage.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types and constants.
// Used by the operand select stage and its mux.
package datapath_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_st_e;

  localparam logic SEL_ERR_FILL = 1'b0;

  function automatic skid_st_e skid_state(
    input logic main_v,
    input logic skid_v
  );
    if (skid_v) return ST_FULL;
    return main_v ? ST_ONE : ST_EMPTY;
  endfunction

endpackage

// File: rtl/sel_mux_comb.sv
// Combinational N-way word mux.
// Out-of-range selects give fill data and sel_err.
module sel_mux_comb
  import datapath_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = 3,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    sel_err
);

  always_comb begin
    data    = {WIDTH{SEL_ERR_FILL}};
    sel_err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        data    = in_data[k*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand select stage: N-way mux feeding a
// main + skid register pair behind valid/ready.
module operand_sel_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int NUM_IN    = 3,
  parameter int ERR_CNT_W = 8,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ERR_CNT_W-1:0]    err_count
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             skid_v;
  logic             acc;
  logic             con;
  skid_st_e         st;

  sel_mux_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .data    (mux_data),
    .sel_err (mux_err)
  );

  // Ready comes from registered state only.
  assign in_ready = !skid_v && Rst_n;
  assign acc      = in_valid && in_ready;
  assign con      = out_valid && out_ready;
  assign st       = skid_state(out_valid, skid_v);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_data    <= '0;
      out_sel_err <= 1'b0;
      out_valid   <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      skid_v      <= 1'b0;
      err_count   <= '0;
    end else begin
      if (acc && mux_err &&
          (err_count != {ERR_CNT_W{1'b1}}))
        err_count <= err_count + 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
        skid_v    <= 1'b0;
      end else begin
        unique case (st)
          ST_EMPTY: begin
            if (acc) begin
              out_data    <= mux_data;
              out_sel_err <= mux_err;
              out_valid   <= 1'b1;
            end
          end
          ST_ONE: begin
            if (acc && con) begin
              out_data    <= mux_data;
              out_sel_err <= mux_err;
            end else if (acc) begin
              skid_data <= mux_data;
              skid_err  <= mux_err;
              skid_v    <= 1'b1;
            end else if (con) begin
              out_valid <= 1'b0;
            end
          end
          ST_FULL: begin
            if (con) begin
              out_data    <= skid_data;
              out_sel_err <= skid_err;
              skid_v      <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed and randomised checks for operand_sel_stage.
// Extra instances cover other NUM_IN/WIDTH values.
module tb_operand_sel_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [95:0] in_data = '0;
  logic [1:0]  sel = '0;
  logic        in_ready, out_valid, out_sel_err;
  logic [31:0] out_data;
  logic [7:0]  err_count;

  operand_sel_stage dut (
    .Clk(clk), .Rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count)
  );

  logic sw_valid = 1'b0;
  logic sw_oready = 1'b1;
  logic sw_flush = 1'b0;

  logic [15:0]  d0 = '0;
  logic         s0 = '0;
  logic [7:0]   o0, c0;
  logic         e0, v0, r0;
  logic [319:0] d1 = '0;
  logic [2:0]   s1 = '0;
  logic [63:0]  o1;
  logic [7:0]   c1;
  logic         e1, v1, r1;
  logic [127:0] d2 = '0;
  logic [3:0]   s2 = '0;
  logic [7:0]   o2, c2;
  logic         e2, v2, r2;

  operand_sel_stage #(.WIDTH(8), .NUM_IN(2)) dut0 (
    .Clk(clk), .Rst_n(rst_n), .in_data(d0), .sel(s0),
    .in_valid(sw_valid), .in_ready(r0), .flush(sw_flush),
    .out_data(o0), .out_sel_err(e0), .out_valid(v0),
    .out_ready(sw_oready), .err_count(c0)
  );

  operand_sel_stage #(.WIDTH(64), .NUM_IN(5)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .in_data(d1), .sel(s1),
    .in_valid(sw_valid), .in_ready(r1), .flush(sw_flush),
    .out_data(o1), .out_sel_err(e1), .out_valid(v1),
    .out_ready(sw_oready), .err_count(c1)
  );

  operand_sel_stage #(.WIDTH(8), .NUM_IN(16)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .in_data(d2), .sel(s2),
    .in_valid(sw_valid), .in_ready(r2), .flush(sw_flush),
    .out_data(o2), .out_sel_err(e2), .out_valid(v2),
    .out_ready(sw_oready), .err_count(c2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL rst_valid got=%b exp=0", out_valid);
      end
      total++;
      if (out_data !== 32'h0) begin
        bad++; $display("FAIL rst_data got=%h exp=0", out_data);
      end
      total++;
      if (err_count !== 8'h0) begin
        bad++; $display("FAIL rst_errcnt got=%0d exp=0", err_count);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL rst_ready got=%b exp=0", in_ready);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rel_ready got=%b exp=1", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rel_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [1:0]  sv [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] ev [4] = '{32'hA, 32'hB, 32'hC, 32'hA};
    in_data = {32'hC, 32'hB, 32'hA};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = sv[i];
      in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL strm_ready%0d got=%b exp=1", i, in_ready);
      end
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== ev[i] ||
          out_sel_err !== 1'b0) begin
        bad++;
        $display("FAIL strm_word%0d got=%b/%h/%b exp=1/%h/0",
                 i, out_valid, out_data, out_sel_err, ev[i]);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL strm_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int sent = 0;
    int cyc = 0;
    int cnt;
    logic acc;
    while ((sent < 6 || got.size() < 6) && cyc < 40) begin
      in_valid = (sent < 6);
      sel = 2'(sent % 3);
      in_data = {32'h300 + sent, 32'h200 + sent, 32'h100 + sent};
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      cnt = sent - got.size();
      total++;
      if (in_ready !== (cnt < 2)) begin
        bad++;
        $display("FAIL bp_ready c%0d got=%b exp=%b",
                 cyc, in_ready, cnt < 2);
      end
      acc = in_valid && (cnt < 2);
      if (out_valid && out_ready) got.push_back(out_data);
      step();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got.size() != 6) begin
      bad++; $display("FAIL bp_count got=%0d exp=6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== 32'((i % 3 + 1) * 256 + i)) begin
        bad++;
        $display("FAIL bp_order%0d got=%h exp=%h",
                 i, got[i], 32'((i % 3 + 1) * 256 + i));
      end
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 2'd0;
    in_data = {64'h0, 32'h11};
    step();
    in_data = {64'h0, 32'h22};
    step();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
        out_data !== 32'h11) begin
      bad++;
      $display("FAIL fl_full got=%b/%b/%h exp=0/1/11",
               in_ready, out_valid, out_data);
    end
    step();
    total++;
    if (out_data !== 32'h11 || out_sel_err !== 1'b0) begin
      bad++;
      $display("FAIL fl_hold got=%h/%b exp=11/0", out_data, out_sel_err);
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = {64'h0, 32'h33};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL fl_empty got=%b/%b exp=0/1", out_valid, in_ready);
    end
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL fl_errcnt got=%0d exp=0", err_count);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL fl_ghost got=%b exp=0", out_valid);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {64'h0, 32'h55};
    step();
    flush = 1'b1;
    in_data = {64'h0, 32'h66};
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL fl_accdrop got=%b exp=0", out_valid);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = {64'h0, 32'h44};
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h44) begin
      bad++;
      $display("FAIL fl_next got=%b/%h exp=1/44", out_valid, out_data);
    end
    step();
  endtask

  task automatic test_illegal();
    sel = 2'd3;
    in_data = {32'hC, 32'hB, 32'hA};
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 ||
        out_sel_err !== 1'b1) begin
      bad++;
      $display("FAIL ill_word got=%b/%h/%b exp=1/0/1",
               out_valid, out_data, out_sel_err);
    end
    total++;
    if (err_count !== 8'd1) begin
      bad++; $display("FAIL ill_cnt1 got=%0d exp=1", err_count);
    end
    for (int i = 2; i <= 300; i++) begin
      step();
      if (i == 254 || i == 256 || i == 300) begin
        total++;
        if (err_count !== 8'((i > 255) ? 255 : i)) begin
          bad++;
          $display("FAIL ill_sat%0d got=%0d exp=%0d",
                   i, err_count, (i > 255) ? 255 : i);
        end
      end
    end
    in_valid = 1'b0;
    sel = 2'd0;
    step();
  endtask

  task automatic test_midreset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {64'h0, 32'h77};
    step();
    step();
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL mr_full got=%b exp=0", in_ready);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        err_count !== 8'd0) begin
      bad++;
      $display("FAIL mr_rst got=%b/%b/%0d exp=0/0/0",
               out_valid, in_ready, err_count);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL mr_ready got=%b exp=1", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mr_lost got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [8:0]  q0[$];
    logic [64:0] q1[$];
    logic [8:0]  q2[$];
    logic [31:0] r;
    logic        acc, con;
    for (int c = 0; c < 500; c++) begin
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_oready = ($urandom_range(0, 2) != 0);
      r = $urandom;
      s0 = r[0];
      s1 = r[2:0];
      s2 = r[3:0];
      d0 = 16'($urandom);
      for (int k = 0; k < 10; k++) d1[k*32 +: 32] = $urandom;
      for (int k = 0; k < 4; k++) d2[k*32 +: 32] = $urandom;
      #1;
      total++;
      if (v0 !== (q0.size() > 0) || r0 !== (q0.size() < 2) ||
          (q0.size() > 0 && {e0, o0} !== q0[0])) begin
        bad++;
        $display("FAIL sw0 c%0d got=%b/%b/%h exp_n=%0d",
                 c, v0, r0, {e0, o0}, q0.size());
      end
      total++;
      if (v1 !== (q1.size() > 0) || r1 !== (q1.size() < 2) ||
          (q1.size() > 0 && {e1, o1} !== q1[0])) begin
        bad++;
        $display("FAIL sw1 c%0d got=%b/%b/%h exp_n=%0d",
                 c, v1, r1, {e1, o1}, q1.size());
      end
      total++;
      if (v2 !== (q2.size() > 0) || r2 !== (q2.size() < 2) ||
          (q2.size() > 0 && {e2, o2} !== q2[0])) begin
        bad++;
        $display("FAIL sw2 c%0d got=%b/%b/%h exp_n=%0d",
                 c, v2, r2, {e2, o2}, q2.size());
      end
      acc = sw_valid && (q0.size() < 2);
      con = sw_oready && (q0.size() > 0);
      if (con) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (acc) begin
        q0.push_back({1'b0, d0[s0*8 +: 8]});
        q1.push_back((s1 < 3'd5) ? {1'b0, d1[s1*64 +: 64]}
                                 : {1'b1, 64'h0});
        q2.push_back({1'b0, d2[s2*8 +: 8]});
      end
      step();
    end
    sw_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_illegal();
    test_midreset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
